// File: rtl/cudacore_pkg.sv
// cudacore_pkg -- definitions shared by the cudacore issue path.
//
// Contents:
//   CORE_DATA_W / CORE_OP_W : operand and opcode widths of the cudacore datapath
//   arb_state_t             : issue-arbiter flush FSM states
//   OP_*                    : opcode encodings shared with intalu
//   rr_advance()            : round-robin successor of a requester ID
package cudacore_pkg;

  localparam int CORE_DATA_W = 32;
  localparam int CORE_OP_W   = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2,
    HOLD  = 2'd3
  } arb_state_t;

  // Opcode map understood by intalu.
  localparam logic [CORE_OP_W-1:0] OP_ADD = 4'h0;
  localparam logic [CORE_OP_W-1:0] OP_SUB = 4'h1;
  localparam logic [CORE_OP_W-1:0] OP_MUL = 4'h2;
  localparam logic [CORE_OP_W-1:0] OP_MAD = 4'h3;
  localparam logic [CORE_OP_W-1:0] OP_AND = 4'h4;
  localparam logic [CORE_OP_W-1:0] OP_OR  = 4'h5;
  localparam logic [CORE_OP_W-1:0] OP_XOR = 4'h6;
  localparam logic [CORE_OP_W-1:0] OP_SHL = 4'h7;
  localparam logic [CORE_OP_W-1:0] OP_SHR = 4'h8;

  // Next requester after `id` in a ring of `n` requesters.
  function automatic int unsigned rr_advance(input int unsigned id, input int unsigned n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/core_tag_fifo.sv
// core_tag_fifo -- in-order FIFO of requester tags for issued cudacore ops.
//
// Ports:
//   clk, rst      : clock, synchronous active-low reset
//   push, din     : append a tag (accepted when not full, or when full with a pop)
//   pop           : remove the head tag (ignored while empty)
//   dout          : head tag, combinational
//   empty, full   : occupancy flags
//   count         : number of stored tags (0..DEPTH)
//
// DEPTH must be a power of two so the pointers wrap naturally.
module core_tag_fifo
  import cudacore_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int TAG_W = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [TAG_W-1:0] din,
  output logic [TAG_W-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_pop;
  logic             do_push;

  assign empty  = (cnt == '0);
  assign full   = (cnt == CNT_W'(DEPTH));
  assign count  = cnt;
  assign dout   = mem[rd_ptr];

  // A push into a full FIFO is allowed when the head leaves in the same
  // cycle: the write lands in the slot being vacated.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Tag storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/core_issue_arbiter.sv
// core_issue_arbiter -- round-robin issue arbiter sharing one cudacore
// datapath among NUM_REQ thread-lane requesters.
//
// Ports:
//   clk, rst                       : clock, synchronous active-low reset
//   req_valid / req_ready          : per-requester handshake (ready is combinational)
//   req_dataA/B/C, req_opcode      : packed per-requester operands/opcode
//   I_dataA/B/C, I_opcode, I_ctrl  : registered issue bundle to cudacore
//   O_data, O_ctrl                 : in-order core results
//   rsp_valid, rsp_id, rsp_data    : result routed back to the owning requester
//   flush_req / flush_done         : stop issue and drain; one-cycle done pulse
//   inflight                       : ops issued and not yet returned
//   err_underflow                  : sticky, a result arrived with no op in flight
//
// Optional build macro CORE_ISSUE_ARB_STATS_EN adds the stat_issued and
// stat_stall counters and their output ports.
module core_issue_arbiter
  import cudacore_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int MAX_INFLIGHT = 4,
  parameter  int ID_W         = $clog2(NUM_REQ),
  localparam int IF_W         = $clog2(MAX_INFLIGHT) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*CORE_DATA_W-1:0] req_dataA,
  input  logic [NUM_REQ*CORE_DATA_W-1:0] req_dataB,
  input  logic [NUM_REQ*CORE_DATA_W-1:0] req_dataC,
  input  logic [NUM_REQ*CORE_OP_W-1:0]   req_opcode,
  output logic [CORE_DATA_W-1:0]         I_dataA,
  output logic [CORE_DATA_W-1:0]         I_dataB,
  output logic [CORE_DATA_W-1:0]         I_dataC,
  output logic [CORE_OP_W-1:0]           I_opcode,
  output logic                           I_ctrl,
  input  logic [CORE_DATA_W-1:0]         O_data,
  input  logic                           O_ctrl,
  output logic                           rsp_valid,
  output logic [ID_W-1:0]                rsp_id,
  output logic [CORE_DATA_W-1:0]         rsp_data,
  input  logic                           flush_req,
  output logic                           flush_done,
  output logic [IF_W-1:0]                inflight,
`ifdef CORE_ISSUE_ARB_STATS_EN
  output logic [31:0]                    stat_issued,
  output logic [31:0]                    stat_stall,
`endif
  output logic                           err_underflow
);

  arb_state_t               state;
  logic [ID_W-1:0]          rr_ptr;
  logic [ID_W-1:0]          grant_id;
  logic                     grant_found;
  logic [ID_W-1:0]          cand;
  int unsigned              scan;
  logic                     can_issue;
  logic                     xfer;

  logic                     fifo_empty;
  logic                     fifo_full;
  logic [ID_W-1:0]          fifo_dout;
  logic [IF_W-1:0]          fifo_count;

  logic [CORE_DATA_W-1:0]   data_a_p1;
  logic [CORE_DATA_W-1:0]   data_b_p1;
  logic [CORE_DATA_W-1:0]   data_c_p1;
  logic [CORE_OP_W-1:0]     opcode_p1;
  logic                     vld_p1;

  // Issue is refused the very cycle flush_req is seen, and while the tag
  // FIFO is full even if a result frees a slot this cycle.
  assign can_issue = (state == RUN) && !flush_req && !fifo_full;

  // Round-robin scan starting at rr_ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    scan        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = (int'(rr_ptr) + k) % NUM_REQ;
      cand = ID_W'(scan);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  assign req_ready = (grant_found && can_issue) ? (NUM_REQ'(1) << grant_id) : '0;
  assign xfer      = grant_found && can_issue;

  core_tag_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .TAG_W (ID_W)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (xfer),
    .pop   (O_ctrl),
    .din   (grant_id),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign inflight  = fifo_count;
  assign rsp_valid = O_ctrl;
  assign rsp_data  = O_data;
  assign rsp_id    = fifo_empty ? '0 : fifo_dout;

  // ---- stage p1: registered issue bundle to the core ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_a_p1 <= '0;
      data_b_p1 <= '0;
      data_c_p1 <= '0;
      opcode_p1 <= '0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= xfer;
      if (xfer) begin
        data_a_p1 <= req_dataA[int'(grant_id)*CORE_DATA_W +: CORE_DATA_W];
        data_b_p1 <= req_dataB[int'(grant_id)*CORE_DATA_W +: CORE_DATA_W];
        data_c_p1 <= req_dataC[int'(grant_id)*CORE_DATA_W +: CORE_DATA_W];
        opcode_p1 <= req_opcode[int'(grant_id)*CORE_OP_W +: CORE_OP_W];
      end
    end
  end

  assign I_dataA  = data_a_p1;
  assign I_dataB  = data_b_p1;
  assign I_dataC  = data_c_p1;
  assign I_opcode = opcode_p1;
  assign I_ctrl   = vld_p1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= ID_W'(rr_advance(int'(grant_id), NUM_REQ));
    end
  end

  // Flush FSM. flush_done is registered and only raised on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RUN;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        RUN: begin
          if (flush_req) state <= DRAIN;
        end
        DRAIN: begin
          if (fifo_empty && !O_ctrl) begin
            state      <= DONE;
            flush_done <= 1'b1;
          end
        end
        DONE: begin
          state <= flush_req ? HOLD : RUN;
        end
        HOLD: begin
          if (!flush_req) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_underflow <= 1'b0;
    end else if (O_ctrl && fifo_empty) begin
      err_underflow <= 1'b1;
    end
  end

`ifdef CORE_ISSUE_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (xfer) stat_issued <= stat_issued + 32'd1;
      if ((|req_valid) && !xfer) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_issue_arbiter.sv
// tb_core_issue_arbiter -- directed scoreboard bench for core_issue_arbiter.
// The driver issues requests and plays the core's result port; expected issue
// bundles and responses are queued as stimulus is applied, and a monitor pops
// and compares whenever I_ctrl or rsp_valid is presented.
module tb_core_issue_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int MAX_INFLIGHT = 4;
  localparam int ID_W         = 2;
  localparam int IF_W         = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_dataA = '0;
  logic [NUM_REQ*32-1:0] req_dataB = '0;
  logic [NUM_REQ*32-1:0] req_dataC = '0;
  logic [NUM_REQ*4-1:0]  req_opcode = '0;
  logic [31:0]           I_dataA, I_dataB, I_dataC;
  logic [3:0]            I_opcode;
  logic                  I_ctrl;
  logic [31:0]           O_data = '0;
  logic                  O_ctrl = 1'b0;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_data;
  logic                  flush_req = 1'b0;
  logic                  flush_done;
  logic [IF_W-1:0]       inflight;
  logic                  err_underflow;

  core_issue_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dataA     (req_dataA),
    .req_dataB     (req_dataB),
    .req_dataC     (req_dataC),
    .req_opcode    (req_opcode),
    .I_dataA       (I_dataA),
    .I_dataB       (I_dataB),
    .I_dataC       (I_dataC),
    .I_opcode      (I_opcode),
    .I_ctrl        (I_ctrl),
    .O_data        (O_data),
    .O_ctrl        (O_ctrl),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_data      (rsp_data),
    .flush_req     (flush_req),
    .flush_done    (flush_done),
    .inflight      (inflight),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [3:0]  op;
  } issue_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
  } rsp_t;

  issue_t exp_issue[$];
  rsp_t   exp_rsp[$];
  issue_t ei;
  rsp_t   er;
  int     checks = 0;
  int     errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Requester i carries A=10+i, B=20+i, C=30+i, op=i unless overridden.
  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [3:0] op);
    req_dataA[32*i +: 32] = a;
    req_dataB[32*i +: 32] = b;
    req_dataC[32*i +: 32] = c;
    req_opcode[4*i +: 4]  = op;
  endtask

  task automatic expect_issue_std(input int i);
    exp_issue.push_back('{a: 32'(10 + i), b: 32'(20 + i), c: 32'(30 + i), op: 4'(i)});
  endtask

  task automatic expect_rsp(input int id, input logic [31:0] data);
    exp_rsp.push_back('{id: ID_W'(id), data: data});
  endtask

  task automatic do_reset();
    req_valid = '0;
    O_ctrl    = 1'b0;
    flush_req = 1'b0;
    rst       = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Monitor: compare every presented issue bundle and response.
  initial begin
    forever begin
      @(negedge clk);
      if (I_ctrl === 1'b1) begin
        if (exp_issue.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL issue_unexpected: got I_ctrl=1 I_dataA=0x%0h expected no issue at %0t", I_dataA, $time);
        end else begin
          ei = exp_issue.pop_front();
          check("issue_dataA", I_dataA, ei.a);
          check("issue_dataB", I_dataB, ei.b);
          check("issue_dataC", I_dataC, ei.c);
          check("issue_opcode", 32'(I_opcode), 32'(ei.op));
        end
      end
      if (rsp_valid === 1'b1) begin
        if (exp_rsp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got rsp_id=%0d rsp_data=0x%0h expected no response at %0t", rsp_id, rsp_data, $time);
        end else begin
          er = exp_rsp.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(er.id));
          check("rsp_data", rsp_data, er.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'(10 + i), 32'(20 + i), 32'(30 + i), 4'(i));

    // Reset state
    do_reset();
    check("rst_I_ctrl", 32'(I_ctrl), 32'd0);
    check("rst_I_dataA", I_dataA, 32'd0);
    check("rst_inflight", 32'(inflight), 32'd0);
    check("rst_flush_done", 32'(flush_done), 32'd0);
    check("rst_err_underflow", 32'(err_underflow), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);

    // Single op from requester 2: 5 + 7 -> 12
    set_req(2, 32'd5, 32'd7, 32'd0, 4'd0);
    req_valid = 4'b0100;
    settle();
    check("single_ready", 32'(req_ready), 32'b0100);
    exp_issue.push_back('{a: 32'd5, b: 32'd7, c: 32'd0, op: 4'd0});
    tick();
    req_valid = '0;
    set_req(2, 32'd12, 32'd22, 32'd32, 4'd2);
    check("single_inflight1", 32'(inflight), 32'd1);
    expect_rsp(2, 32'd12);
    O_ctrl = 1'b1;
    O_data = 32'd12;
    tick();
    O_ctrl = 1'b0;
    check("single_inflight0", 32'(inflight), 32'd0);

    // Round robin with all requesters valid and no returns
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      settle();
      check("rr_ready", 32'(req_ready), 32'(1 << k));
      expect_issue_std(k);
      tick();
    end
    check("rr_full_ready", 32'(req_ready), 32'd0);
    check("rr_full_inflight", 32'(inflight), 32'd4);
    tick();
    check("rr_full_ready_hold", 32'(req_ready), 32'd0);
    expect_rsp(0, 32'd100);
    O_ctrl = 1'b1;
    O_data = 32'd100;
    settle();
    check("rr_full_ready_on_return", 32'(req_ready), 32'd0);
    tick();
    O_ctrl = 1'b0;
    settle();
    check("rr_after_return_inflight", 32'(inflight), 32'd3);
    check("rr_next_grant0", 32'(req_ready), 32'b0001);
    expect_issue_std(0);
    tick();
    req_valid = '0;
    check("rr_refill_inflight", 32'(inflight), 32'd4);
    expect_rsp(1, 32'd101);
    O_ctrl = 1'b1;
    O_data = 32'd101;
    tick();
    expect_rsp(2, 32'd102);
    O_data = 32'd102;
    tick();
    O_ctrl = 1'b0;
    check("sim_pre_inflight", 32'(inflight), 32'd2);

    // Simultaneous issue and return at inflight=2
    req_valid = 4'b0010;
    expect_rsp(3, 32'd103);
    O_ctrl = 1'b1;
    O_data = 32'd103;
    settle();
    check("sim_ready", 32'(req_ready), 32'b0010);
    check("sim_rsp_id_oldest", 32'(rsp_id), 32'd3);
    expect_issue_std(1);
    tick();
    req_valid = '0;
    O_ctrl = 1'b0;
    check("sim_inflight", 32'(inflight), 32'd2);
    expect_rsp(0, 32'd104);
    O_ctrl = 1'b1;
    O_data = 32'd104;
    tick();
    expect_rsp(1, 32'd105);
    O_data = 32'd105;
    tick();
    O_ctrl = 1'b0;
    check("sim_drained", 32'(inflight), 32'd0);

    // Flush with three ops in flight (pointer is at 2)
    req_valid = 4'b1111;
    foreach (exp_rsp[j]) begin end
    for (int n = 0; n < 3; n++) begin
      int k;
      k = (2 + n) % 4;
      settle();
      check("fl_ready", 32'(req_ready), 32'(1 << k));
      expect_issue_std(k);
      tick();
    end
    flush_req = 1'b1;
    settle();
    check("fl_block_same_cycle", 32'(req_ready), 32'd0);
    tick();
    check("fl_drain_ready", 32'(req_ready), 32'd0);
    for (int n = 0; n < 3; n++) begin
      expect_rsp((2 + n) % 4, 32'(200 + n));
      O_ctrl = 1'b1;
      O_data = 32'(200 + n);
      settle();
      check("fl_drain_ready_ret", 32'(req_ready), 32'd0);
      tick();
    end
    O_ctrl = 1'b0;
    check("fl_inflight0", 32'(inflight), 32'd0);
    check("fl_done_not_yet", 32'(flush_done), 32'd0);
    tick();
    check("fl_done_pulse", 32'(flush_done), 32'd1);
    check("fl_done_ready", 32'(req_ready), 32'd0);
    tick();
    check("fl_hold_done_low", 32'(flush_done), 32'd0);
    check("fl_hold_ready", 32'(req_ready), 32'd0);
    tick();
    check("fl_hold_ready2", 32'(req_ready), 32'd0);
    flush_req = 1'b0;
    settle();
    check("fl_hold_drop_ready", 32'(req_ready), 32'd0);
    tick();
    check("fl_resume_ready", 32'(req_ready), 32'b0010);
    expect_issue_std(1);
    tick();
    req_valid = '0;
    expect_rsp(1, 32'd210);
    O_ctrl = 1'b1;
    O_data = 32'd210;
    tick();
    O_ctrl = 1'b0;

    // Underflow: result with nothing in flight
    check("uf_before", 32'(err_underflow), 32'd0);
    expect_rsp(0, 32'd99);
    O_ctrl = 1'b1;
    O_data = 32'd99;
    settle();
    check("uf_rsp_id", 32'(rsp_id), 32'd0);
    tick();
    O_ctrl = 1'b0;
    check("uf_set", 32'(err_underflow), 32'd1);
    tick();
    check("uf_sticky", 32'(err_underflow), 32'd1);
    check("uf_inflight", 32'(inflight), 32'd0);

    // Reset mid-stream with three ops in flight (pointer is at 2)
    req_valid = 4'b1111;
    for (int n = 0; n < 3; n++) begin
      expect_issue_std((2 + n) % 4);
      tick();
    end
    req_valid = '0;
    check("mr_inflight3", 32'(inflight), 32'd3);
    rst = 1'b0;
    tick();
    check("mr_inflight0", 32'(inflight), 32'd0);
    check("mr_I_ctrl", 32'(I_ctrl), 32'd0);
    check("mr_err_cleared", 32'(err_underflow), 32'd0);
    rst = 1'b1;
    req_valid = 4'b1010;
    settle();
    check("mr_lowest_grant", 32'(req_ready), 32'b0010);
    expect_issue_std(1);
    tick();
    req_valid = '0;
    expect_rsp(1, 32'd300);
    O_ctrl = 1'b1;
    O_data = 32'd300;
    tick();
    O_ctrl = 1'b0;
    tick();
    tick();

    check("sb_issue_empty", 32'(exp_issue.size()), 32'd0);
    check("sb_rsp_empty", 32'(exp_rsp.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_issue_arbiter.md
Name: core_issue_arbiter

Overview:
- Round-robin issue arbiter that shares one cudacore datapath (intalu + regfile pipeline) among NUM_REQ thread-lane requesters.
- Grants one operand/opcode bundle per cycle, drives the core's I_* inputs from registers, and tags each issued op with its requester ID in an in-order tag FIFO.
- Routes each core result (O_ctrl/O_data) back to the owning requester.
- Supports a flush sequence that stops issue and drains in-flight ops.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_INFLIGHT, 4, tag FIFO depth and limit on issued-but-unreturned ops (power of 2).
- ID_W, $clog2(NUM_REQ), requester ID width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  per-requester op valid
- req_ready  out  NUM_REQ  per-requester accept (combinational)
- req_dataA  in  NUM_REQ*32  operand A per requester, requester i at [32i+:32]
- req_dataB  in  NUM_REQ*32  operand B, same packing
- req_dataC  in  NUM_REQ*32  operand C, same packing
- req_opcode  in  NUM_REQ*4  opcode per requester
- I_dataA/I_dataB/I_dataC  out  32 each  registered operands to cudacore
- I_opcode  out  4  registered opcode to cudacore
- I_ctrl  out  1  issue-valid strobe to cudacore
- O_data  in  32  core result
- O_ctrl  in  1  core result valid
- rsp_valid  out  1  result valid to requesters
- rsp_id  out  ID_W  owning requester of rsp_data
- rsp_data  out  32  result data
- flush_req  in  1  level request: stop issue and drain
- flush_done  out  1  one-cycle pulse when drained
- inflight  out  $clog2(MAX_INFLIGHT)+1  ops issued and not yet returned
- err_underflow  out  1  sticky: O_ctrl arrived with tag FIFO empty

Behaviour:
- Reset (rst==0 at posedge): I_* = 0, I_ctrl = 0, RR pointer = 0, tag FIFO empty, inflight = 0, flush_done = 0, err_underflow = 0, state = RUN.
- can_issue = (state==RUN) && (inflight < MAX_INFLIGHT).
- Arbitration: grant goes to the first i with req_valid[i], scanning from the RR pointer upward mod NUM_REQ. req_ready[i] = grant[i] && can_issue. At most one req_ready is high.
- Handshake: a transfer occurs when req_valid[i] && req_ready[i]. Requesters must hold valid and data stable until ready.
- On transfer at edge t:
  - I_* take requester i's fields at t+1, with I_ctrl = 1 for exactly one cycle per transfer.
  - Back-to-back transfers give continuous I_ctrl.
  - i is pushed to the tag FIFO.
  - RR pointer becomes (i+1) mod NUM_REQ.
- No transfer: I_ctrl = 0, I_* hold their last values, RR pointer unchanged.
- Response (combinational, zero latency):
  - rsp_valid = O_ctrl, rsp_data = O_data, rsp_id = tag FIFO head.
  - The tag is popped on O_ctrl. Results are in order; there is no response backpressure.
- inflight:
  - +1 on transfer, -1 on O_ctrl (when the FIFO is non-empty).
  - Both in the same cycle: unchanged, and the FIFO push and pop both occur.
  - When inflight == MAX_INFLIGHT, req_ready is all 0, even if O_ctrl is high that cycle (no same-cycle credit reuse).
- Underflow: O_ctrl with the FIFO empty sets err_underflow (sticky until reset). There is no pop, and rsp_id = 0.
- FSM:
  - RUN -> DRAIN when flush_req==1. Issue is blocked in the same cycle flush_req is sampled high.
  - DRAIN -> DONE when inflight==0 and no O_ctrl that cycle.
  - DONE: flush_done = 1 for one cycle, then -> RUN if flush_req==0, else stay in HOLD until flush_req drops. HOLD has no issue and flush_done = 0; HOLD -> RUN when flush_req drops.
  - flush_req asserted with inflight==0: RUN -> DRAIN -> DONE, so flush_done is high 2 cycles after flush_req is sampled.
- Reset mid-operation: all state is discarded immediately, and results arriving after reset count as underflow. The integrator resets the core in the same cycle.

Optional Feature:
- Macro: CORE_ISSUE_ARB_STATS_EN.
- Defined: adds outputs stat_issued (32b, +1 per transfer) and stat_stall (32b, +1 per cycle with any req_valid but no transfer). Both counters wrap and clear on reset.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package cudacore_pkg:
  - arb_state_t enum {RUN, DRAIN, DONE, HOLD}
  - CORE_DATA_W=32, CORE_OP_W=4
  - opcode constants shared with intalu
- Sub-module core_tag_fifo: synchronous FIFO of ID_W-bit tags, depth MAX_INFLIGHT.
  - Ports: push, pop, din, dout, empty, full, count.
  - Supports simultaneous push/pop when full or empty-with-push.

Test Plan:
- Single op: req_valid[2]=1, A=5, B=7, C=0, op=0 -> req_ready[2]=1 at once; next cycle I_ctrl=1, I_dataA=5, I_opcode=0. Core returns O_ctrl with O_data=12 -> rsp_valid=1, rsp_id=2, rsp_data=12, inflight back to 0.
- Round robin: all 4 requesters valid continuously, no returns -> grants 0,1,2,3. Then inflight=4 and req_ready=0 until the first O_ctrl; the next grant is 0.
- Simultaneous issue and return at inflight=2 -> inflight stays 2; rsp_id equals the oldest tag; the new tag is appended.
- Flush with 3 in flight: flush_req=1 -> no further req_ready. Three O_ctrl pulses give rsp_ids in issue order, then a one-cycle flush_done. With flush_req still held, the block stays in HOLD and resumes issue when it drops.
- Underflow: O_ctrl=1 with nothing issued -> err_underflow=1 and stays 1; rsp_id=0.
- Reset mid-stream: rst=0 with inflight=3 -> next cycle inflight=0, I_ctrl=0, RR pointer 0; the next grant goes to the lowest valid requester.
